// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a; holds defaults and the saturating-increment helper.
package seq_pkg;

  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1011;
  localparam int         DEF_CNT_W     = 8;

  // Widest counter the helper supports; callers zero-extend narrower counts.
  localparam int SAT_MAX_W = 16;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] val;
  } sat_t;

  // Saturating increment: at or above max the value sticks at max and ovf flags the lost event.
  function automatic sat_t sat_inc(input logic [SAT_MAX_W-1:0] val,
                                   input logic [SAT_MAX_W-1:0] max);
    sat_t r;
    if (val >= max) begin
      r.val = max;
      r.ovf = 1'b1;
    end else begin
      r.val = val + 1'b1;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_shift_in_reg.sv
// Serial shift register with a saturating count of valid bits held.
// Latency: one cycle from an accepted bit to sr/fill.
// Backpressure: none; d_valid=0 simply holds state, restart zeroes fill but keeps shifting.
module shift_in_reg
  import seq_pkg::*;
#(
  parameter int W  = DEF_PATTERN_W,
  parameter int FW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_in,
  input  logic          d_valid,
  input  logic          restart,
  output logic [W-1:0]  sr,
  output logic [FW-1:0] fill
);

  localparam logic [FW-1:0] FILL_MAX = FW'(W);

  // Shift in accepted bits; fill counts fresh bits since reset or the last restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      fill <= '0;
    end else if (d_valid) begin
      sr <= {sr[W-2:0], d_in};
      if (restart) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector with one-cycle match pulse and saturating match counter.
// Latency: match/match_count/overflow register one cycle after the completing bit.
// Backpressure: none; d_valid gaps are transparent, held bits survive any number of idle cycles.
module seq_detect
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_in,
  input  logic                 d_valid,
  input  logic                 overlap_en,
  input  logic                 cnt_clr,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic                 overflow,
  output logic [PATTERN_W-1:0] window
);

  localparam int                  FW       = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0]       HIT_FILL = FW'(PATTERN_W - 1);
  localparam logic [SAT_MAX_W-1:0] CNT_MAX = SAT_MAX_W'((1 << CNT_W) - 1);

  logic [PATTERN_W-1:0] sr;
  logic [FW-1:0]        fill;
  logic [PATTERN_W-1:0] nxt;
  logic                 hit;
  logic                 restart;
  sat_t                 inc;

  // A hit needs PATTERN_W fresh bits: the ones already held plus the bit arriving now.
  assign nxt     = {sr[PATTERN_W-2:0], d_in};
  assign hit     = d_valid && (fill >= HIT_FILL) && (nxt == PATTERN);
  assign restart = hit && !overlap_en;
  assign inc     = sat_inc(SAT_MAX_W'(match_count), CNT_MAX);
  assign window  = sr;

  shift_in_reg #(
    .W  (PATTERN_W),
    .FW (FW)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .d_valid (d_valid),
    .restart (restart),
    .sr      (sr),
    .fill    (fill)
  );

  // Register the match pulse and the counter; clear beats a coincident hit but the pulse still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      match       <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      match <= hit;
      if (cnt_clr) begin
        match_count <= '0;
        overflow    <= 1'b0;
      end else if (hit) begin
        match_count <= CNT_W'(inc.val);
        if (inc.ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect: default instance plus a CNT_W=2 instance sharing the same stimulus.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_seq_detect;

  localparam int PW  = 4;
  localparam int PAT = 11;  // 4'b1011

  logic       clk = 1'b0;
  logic       rst, d_in, d_valid, overlap_en, cnt_clr;
  logic       match_a, ovf_a, match_b, ovf_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] win_a, win_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference state
  int m_win, m_since, m_cnt, m_cnt2;
  bit m_match, m_ovf, m_ovf2;

  always #5 clk = ~clk;

  seq_detect u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .match(match_a), .match_count(cnt_a), .overflow(ovf_a), .window(win_a)
  );

  seq_detect #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .match(match_b), .match_count(cnt_b), .overflow(ovf_b), .window(win_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: last PW accepted bits as an integer, fresh-bit count since reset/restart, plain counts.
  always @(posedge clk) begin
    bit hit;
    hit = 1'b0;
    if (rst) begin
      m_win = 0; m_since = 0; m_match = 0;
      m_cnt = 0; m_ovf = 0; m_cnt2 = 0; m_ovf2 = 0;
    end else begin
      if (d_valid) begin
        m_win = ((m_win << 1) | int'(d_in)) % (1 << PW);
        m_since++;
        if (m_since >= PW && m_win == PAT) begin
          hit = 1'b1;
          if (!overlap_en) m_since = 0;
        end
      end
      m_match = hit;
      if (cnt_clr) begin
        m_cnt = 0; m_ovf = 0; m_cnt2 = 0; m_ovf2 = 0;
      end else if (hit) begin
        if (m_cnt == 255) m_ovf = 1; else m_cnt++;
        if (m_cnt2 == 3) m_ovf2 = 1; else m_cnt2++;
      end
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("match_a", 32'(match_a), 32'(m_match));
      chk("cnt_a",   32'(cnt_a),   32'(m_cnt));
      chk("ovf_a",   32'(ovf_a),   32'(m_ovf));
      chk("win_a",   32'(win_a),   32'(m_win));
      chk("match_b", 32'(match_b), 32'(m_match));
      chk("cnt_b",   32'(cnt_b),   32'(m_cnt2));
      chk("ovf_b",   32'(ovf_b),   32'(m_ovf2));
      chk("win_b",   32'(win_b),   32'(m_win));
    end
  end

  task automatic cyc(input logic r, input logic d, input logic v, input logic ov, input logic clr);
    rst = r; d_in = d; d_valid = v; overlap_en = ov; cnt_clr = clr;
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] bits, input logic [15:0] expm, input int n,
                     input logic ov, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, bits[n-1-i], 1'b1, ov, 1'b0);
      chk($sformatf("%s_m%0d", nm, i), 32'(match_a), 32'(expm[n-1-i]));
    end
  endtask

  initial begin
    int hitn;
    int exp_c[5];
    int exp_o[5];
    logic [15:0] sat_bits;
    exp_c = '{1, 2, 3, 3, 3};
    exp_o = '{0, 0, 0, 1, 1};

    // reset held with random inputs
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)));
    chk("rst_match", 32'(match_a), 0);
    chk("rst_cnt",   32'(cnt_a),   0);
    chk("rst_ovf",   32'(ovf_a),   0);
    chk("rst_win",   32'(win_a),   0);
    chk("rst_cnt_b", 32'(cnt_b),   0);
    chk("rst_ovf_b", 32'(ovf_b),   0);
    chk_en = 1'b1;
    run(16'b101, 16'b000, 3, 1'b1, "rst101");

    // overlap
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(16'b1011011, 16'b0001001, 7, 1'b1, "ovl7");
    chk("ovl7_cnt", 32'(cnt_a), 2);

    // non-overlap vs overlap on the same stream
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(16'b1011011011, 16'b0001000001, 10, 1'b0, "novl");
    chk("novl_cnt", 32'(cnt_a), 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(16'b1011011011, 16'b0001001001, 10, 1'b1, "ovl10");
    chk("ovl10_cnt", 32'(cnt_a), 3);

    // valid gaps carrying d_in=0
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] g;
      g = 4'b1011;
      cyc(1'b0, g[3-i], 1'b1, 1'b1, 1'b0);
      chk($sformatf("gap_acc%0d", i), 32'(match_a), (i == 3) ? 1 : 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gap_idle%0d", i), 32'(match_a), 0);
    end
    chk("gap_cnt", 32'(cnt_a), 1);

    // saturation on the CNT_W=2 instance, then clear on a hit edge
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    sat_bits = 16'b1011011011011011;
    hitn = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, sat_bits[15-i], 1'b1, 1'b1, 1'b0);
      if (i % 3 == 0 && i > 0) begin
        chk($sformatf("sat_match%0d", hitn), 32'(match_b), 1);
        chk($sformatf("sat_cnt%0d", hitn), 32'(cnt_b), 32'(exp_c[hitn]));
        chk($sformatf("sat_ovf%0d", hitn), 32'(ovf_b), 32'(exp_o[hitn]));
        hitn++;
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_match_b", 32'(match_b), 1);
    chk("clr_cnt_b",   32'(cnt_b),   0);
    chk("clr_ovf_b",   32'(ovf_b),   0);
    chk("clr_match_a", 32'(match_a), 1);
    chk("clr_cnt_a",   32'(cnt_a),   0);

    // reset mid-pattern
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(16'b101, 16'b000, 3, 1'b1, "pre");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run(16'b1, 16'b0, 1, 1'b1, "post1");
    run(16'b011, 16'b001, 3, 1'b1, "post3");

    // random traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(99) == 0), 1'($urandom_range(1)), 1'($urandom_range(9) < 7),
          1'($urandom_range(1)), 1'($urandom_range(49) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect.md
# seq_detect

Serial pattern detector sitting directly downstream of the reset-able D flip-flop stage. It consumes the registered single-bit stream (the flip-flop's `q`) and raises a one-cycle `match` pulse each time the last `PATTERN_W` accepted bits equal `PATTERN`. It optionally counts matches with saturation and sticky overflow. Overlapping and non-overlapping detection are selectable at run time.

## Interface
- `PATTERN_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1011: target sequence; MSB is the oldest bit, LSB the newest.
- `CNT_W`, default 8: match counter width; legal range 2..16.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  1  serial data bit, driven from the upstream flip-flop `q`.
- `d_valid`  in  1  `d_in` is accepted on this edge only when this is 1.
- `overlap_en`  in  1  1 = overlapping detection; 0 = window restarts after a match.
- `cnt_clr`  in  1  synchronous clear of `match_count` and `overflow`.
- `match`  out  1  registered; high for exactly one cycle per detected pattern.
- `match_count`  out  CNT_W  number of matches since reset/clear; saturating.
- `overflow`  out  1  sticky; set when a match occurs while the count is saturated.
- `window`  out  PATTERN_W  current shift-register contents, for debug.

## Operation
- State:
  - `sr` [PATTERN_W-1:0]: the shift register.
  - `fill`: count of valid bits held, 0..PATTERN_W, saturating at PATTERN_W.
- Reset (`rst`=1 at an edge): `sr`=0, `fill`=0, `match`=0, `match_count`=0, `overflow`=0, `window`=0. Reset overrides every other input.
- Accept (`d_valid`=1):
  - `nxt` = {`sr`[PATTERN_W-2:0], `d_in`}.
  - `sr` <= `nxt`.
  - `fill` <= min(`fill`+1, PATTERN_W).
- Hit: `d_valid`=1 AND `fill` >= PATTERN_W-1 AND `nxt`==`PATTERN`.
- On a hit:
  - `match` <= 1.
  - If `overlap_en`=0, `fill` <= 0. The next match then needs PATTERN_W fresh bits.
  - If `overlap_en`=1, `fill` follows the normal accept rule.
- No accept (`d_valid`=0): `sr` and `fill` hold, and `match` <= 0.
- Counter:
  - On a hit, `match_count` increments unless it equals 2^CNT_W-1.
  - If a hit occurs while `match_count` is saturated, `overflow` <= 1.
- `cnt_clr`=1 forces `match_count`<=0 and `overflow`<=0. This applies even on a hit edge: clear wins, the hit is not counted, but the `match` pulse is still issued.
- `overlap_en` is sampled on the hit edge only. Changing it mid-stream has no effect on bits already held.
- `window` is `sr` directly.

## Timing
- Latency: `match` is high in the cycle following the rising edge that accepts the completing bit (1-cycle registered latency).
- `match_count` and `overflow` update on the same edge as `match` rises.
- Back-to-back hits (overlap mode, e.g. PATTERN=1111 fed all ones) keep `match` high on consecutive cycles, one cycle per hit.
- Gaps in `d_valid` are transparent: detection spans them without loss.
- A reset mid-pattern discards all held bits. No match can form from pre-reset bits.
- No combinational path from any input to any output.

## Structure
- Shared package `seq_pkg`:
  - default `PATTERN_W`, `PATTERN`, `CNT_W` constants;
  - a `sat_inc` function (saturating increment, returns value and overflow flag).
- One natural sub-module: `shift_in_reg`. It holds `sr` and `fill`, with ports `clk`, `rst`, `d_in`, `d_valid`, `restart`, `sr`, `fill`.
- The top module `seq_detect` holds the compare logic, `match` register and counter.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with random `d_in`/`d_valid` -> all outputs 0. Release, then feed 101 -> `match` stays 0.
- Overlap, PATTERN=1011: stream 1,0,1,1,0,1,1 with `d_valid`=1 -> `match` pulses after bits 4 and 7, `match_count`=2.
- Non-overlap, same pattern: stream 1,0,1,1,0,1,1,0,1,1 -> pulses after bits 4 and 10 only, `match_count`=2. With overlap on, the same stream gives pulses after bits 4, 7 and 10.
- Valid gaps: 1,0,1,1 interleaved with `d_valid`=0 cycles carrying `d_in`=0 -> exactly one pulse, one cycle after the 4th accepted bit.
- Saturation, CNT_W=2: 5 hits -> `match_count` 1,2,3,3,3; `overflow` sets on the 4th hit. Then `cnt_clr` on a hit edge -> `match_count`=0, `overflow`=0, `match`=1.
- Reset mid-stream: feed 1,0,1, assert `rst` for one cycle, then feed 1 -> no match. Then feed 0,1,1 -> match.
